fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the pipelined KGP RISC core. Owns the PC and
//  drives the combinational instruction memory (word-addressed, 64 x 32). Loads
//  the IF/ID pipeline register.
//  Handles the following:
//   - hazard stalls
//   - branch/jump redirects with flush
//   - halt on the memory's end-of-program flag (pc_en low, i.e. sentinel word).
// PARAMETERS
//  ADDR_W     6              PC / imem address width (word address)
//  RESET_PC   0              PC value after reset
//  CNT_W      16             width of fetch_count
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       leave IDLE and begin fetching at current pc
//  stall        in   1       hazard unit: hold PC and IF/ID contents
//  redirect     in   1       taken branch/jump resolved downstream
//  redirect_pc  in   ADDR_W  target word address for redirect
//  imem_instr   in   32      instr word from instr memory (same-cycle read)
//  imem_pc_en   in   1       instr memory valid flag; 0 = sentinel/end of program
//  imem_read    out  1       read strobe to instr memory
//  imem_addr    out  ADDR_W  address to instr memory (= pc)
//  ifid_instr   out  32      IF/ID register: fetched instruction
//  ifid_pc      out  ADDR_W  IF/ID register: address of ifid_instr
//  ifid_valid   out  1       IF/ID register holds a real instruction
//  halted       out  1       end of program reached, fetch stopped
//  fetch_count  out  CNT_W   instructions issued into IF/ID (saturating)
// BEHAVIOUR
//  Reset (rst=1 at an edge, from any state, including mid-stall or mid-redirect):
//   - state=IDLE, pc=RESET_PC
//   - ifid_instr=0, ifid_pc=0, ifid_valid=0, halted=0, fetch_count=0.
//  Outputs:
//   - imem_addr = pc combinationally in all states.
//   - imem_read = 1 only in RUN, else 0.
//  States:
//   - IDLE -> RUN when start=1. Nothing else happens; redirect and stall are
//     ignored in IDLE.
//   - RUN: per-cycle priority is redirect > stall > halt check > normal fetch.
//     - redirect: pc<=redirect_pc, ifid_valid<=0, ifid_instr<=0 (flush).
//       Count is not incremented. Redirect wins even when stall=1.
//     - stall (no redirect): pc, ifid_*, fetch_count hold.
//     - imem_pc_en=0: state<=HALT, halted<=1, ifid_valid<=0. pc holds at the
//       sentinel address.
//     - normal fetch:
//       - ifid_instr<=imem_instr, ifid_pc<=pc, ifid_valid<=1
//       - pc<=pc+1, which wraps modulo 2^ADDR_W (63 -> 0)
//       - fetch_count<=fetch_count+1, saturating at all-ones.
//   - HALT: halted=1, imem_read=0, ifid_valid=0.
//     - redirect=1: pc<=redirect_pc, halted<=0, state<=RUN. This covers a branch
//       still in flight when the sentinel was fetched.
//     - Otherwise stays until rst. stall and start are ignored in HALT.
//  Latency and widths:
//   - The word at pc appears on ifid_* on the edge after it is addressed.
//   - Redirect target appears on ifid_* 2 edges after redirect is sampled
//     (1 flush bubble).
//   - imem_instr is never latched while imem_pc_en=0, so X never reaches IF/ID.
// TESTING
//  1. rst, start, imem returns 0x11,0x22,0x33 at addr 0..2 ->
//     ifid_pc=0,1,2 on consecutive edges, ifid_valid=1, fetch_count=3.
//  2. stall=1 for 2 cycles at pc=5 -> pc stays 5, ifid_instr/ifid_pc unchanged,
//     fetch_count unchanged; resumes at 5 after release.
//  3. redirect=1 with stall=1, redirect_pc=20 at pc=7 -> next edge ifid_valid=0,
//     pc=20; following edge ifid_pc=20, ifid_valid=1.
//  4. imem_pc_en=0 at addr 9 -> halted=1, imem_read=0, ifid_valid=0, pc=9;
//     then redirect_pc=3 -> RUN, ifid_pc=3 two edges later.
//  5. pc=63 normal fetch -> ifid_pc=63, pc wraps to 0.
//  6. rst asserted mid-stall in RUN -> next edge all outputs at reset values,
//     state IDLE, imem_read=0 until start.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC and loading the IF/ID register.
module fetch_ctrl #(
    parameter int ADDR_W = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [31:0]       imem_instr,
    input  logic              imem_pc_en,
    output logic              imem_read,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              ifid_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n, ifid_pc_n;
    logic [31:0]         instr_n;
    logic                valid_n, halted_n;
    logic [CNT_W-1:0]    count_n;

    assign imem_addr = pc;
    assign imem_read = state == RUN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ifid_instr  <= '0;
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            ifid_instr  <= instr_n;
            ifid_pc     <= ifid_pc_n;
            ifid_valid  <= valid_n;
            halted      <= halted_n;
            fetch_count <= count_n;
        end
    end

    // Priority in RUN: redirect > stall > end-of-program > normal fetch.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        instr_n   = ifid_instr;
        ifid_pc_n = ifid_pc;
        valid_n   = ifid_valid;
        halted_n  = halted;
        count_n   = fetch_count;
        if (state == IDLE) begin
            if (start) state_n = RUN;
        end else if (state == RUN) begin
            if (redirect) begin
                pc_n    = redirect_pc;
                valid_n = 1'b0;
                instr_n = '0;
            end else if (!stall) begin
                if (!imem_pc_en) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                    valid_n  = 1'b0;
                end else begin
                    instr_n   = imem_instr;
                    ifid_pc_n = pc;
                    valid_n   = 1'b1;
                    pc_n      = pc + 1'b1;
                    count_n   = &fetch_count ? fetch_count : fetch_count + 1'b1;
                end
            end
        end else if (redirect) begin
            pc_n     = redirect_pc;
            halted_n = 1'b0;
            state_n  = RUN;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a queue of expected IF/ID contents checked by a monitor.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, stall, redirect;
    logic [5:0]  redirect_pc;
    logic [31:0] imem_instr;
    logic        imem_pc_en;
    logic        imem_read;
    logic [5:0]  imem_addr;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_pc;
    logic        ifid_valid, halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];
    logic [63:0] en;

    // chk: 0 none, 1 valid only, 2 valid+instr, 3 valid+instr+pc
    typedef struct {
        int          chk;
        logic        valid;
        logic [5:0]  pc;
        logic [31:0] instr;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_instr(imem_instr), .imem_pc_en(imem_pc_en),
        .imem_read(imem_read), .imem_addr(imem_addr), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];
    assign imem_pc_en = en[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk >= 1) check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
            if (e.chk >= 2) check("ifid_instr", ifid_instr, e.instr);
            if (e.chk >= 3) check("ifid_pc", {26'b0, ifid_pc}, {26'b0, e.pc});
        end
    end

    task automatic step(input int chk, input logic v, input logic [5:0] p, input logic [31:0] i);
        exp_t e;
        e.chk = chk; e.valid = v; e.pc = p; e.instr = i;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_read", {31'b0, imem_read}, 0);
        check("rst_imem_addr", {26'b0, imem_addr}, 0);
        check("rst_ifid_valid", {31'b0, ifid_valid}, 0);
        check("rst_ifid_pc", {26'b0, ifid_pc}, 0);
        check("rst_ifid_instr", ifid_instr, 0);
        check("rst_halted", {31'b0, halted}, 0);
        check("rst_fetch_count", {16'b0, fetch_count}, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        en = '1;
        rst = 1; start = 0; stall = 0; redirect = 0; redirect_pc = 0;
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_reset_outputs();
        rst = 0;
        step(3, 0, 0, 0);
        check("idle_no_read", {31'b0, imem_read}, 0);
        start = 1;
        step(3, 0, 0, 0);
        start = 0;
        check("run_read", {31'b0, imem_read}, 1);
        // basic fetch of 0x11/0x22/0x33
        step(3, 1, 0, 32'h11);
        step(3, 1, 1, 32'h22);
        step(3, 1, 2, 32'h33);
        check("count3", {16'b0, fetch_count}, 3);
        check("addr3", {26'b0, imem_addr}, 3);
        step(3, 1, 3, mem[3]);
        step(3, 1, 4, mem[4]);
        // stall at pc=5
        stall = 1;
        step(3, 1, 4, mem[4]);
        step(3, 1, 4, mem[4]);
        check("stall_pc", {26'b0, imem_addr}, 5);
        check("stall_count", {16'b0, fetch_count}, 5);
        stall = 0;
        step(3, 1, 5, mem[5]);
        step(3, 1, 6, mem[6]);
        // redirect wins over stall at pc=7
        check("pre_redir_pc", {26'b0, imem_addr}, 7);
        stall = 1; redirect = 1; redirect_pc = 20;
        step(2, 0, 0, 0);
        stall = 0; redirect = 0;
        check("redir_pc", {26'b0, imem_addr}, 20);
        check("redir_count", {16'b0, fetch_count}, 7);
        step(3, 1, 20, mem[20]);
        check("post_redir_count", {16'b0, fetch_count}, 8);
        // halt on sentinel at 9
        redirect = 1; redirect_pc = 8;
        step(2, 0, 0, 0);
        redirect = 0; en[9] = 0;
        step(3, 1, 8, mem[8]);
        step(1, 0, 0, 0);
        check("halted", {31'b0, halted}, 1);
        check("halt_read", {31'b0, imem_read}, 0);
        check("halt_addr", {26'b0, imem_addr}, 9);
        check("halt_count", {16'b0, fetch_count}, 9);
        stall = 1; start = 1;
        step(1, 0, 0, 0);
        check("halt_hold", {31'b0, halted}, 1);
        check("halt_hold_addr", {26'b0, imem_addr}, 9);
        stall = 0; start = 0; redirect = 1; redirect_pc = 3;
        step(1, 0, 0, 0);
        redirect = 0; en[9] = 1;
        check("unhalt", {31'b0, halted}, 0);
        check("unhalt_read", {31'b0, imem_read}, 1);
        check("unhalt_addr", {26'b0, imem_addr}, 3);
        step(3, 1, 3, mem[3]);
        check("unhalt_count", {16'b0, fetch_count}, 10);
        // wrap at 63
        redirect = 1; redirect_pc = 63;
        step(2, 0, 0, 0);
        redirect = 0;
        step(3, 1, 63, mem[63]);
        check("wrap_addr", {26'b0, imem_addr}, 0);
        check("wrap_count", {16'b0, fetch_count}, 11);
        // reset mid-stall
        stall = 1;
        step(3, 1, 63, mem[63]);
        rst = 1;
        step(3, 0, 0, 0);
        rst = 0; stall = 0;
        check_reset_outputs();
        step(3, 0, 0, 0);
        check("idle_after_rst", {31'b0, imem_read}, 0);
        start = 1;
        step(3, 0, 0, 0);
        start = 0;
        step(3, 1, 0, 32'h11);
        check("restart_count", {16'b0, fetch_count}, 1);
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
